// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame controller.
package serial_frame_pkg;

    // Frame sequencing states, in link order.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWrLo,
        StWrHi,
        StRdLo,
        StRdHi,
        StEnd
    } sfc_state_e;

    // Cycles from the start-sampling edge to the done cycle, inclusive.
    function automatic int unsigned frame_cycles(input int unsigned cmd_bits,
                                                 input int unsigned data_bits,
                                                 input int unsigned half_cyc,
                                                 input int unsigned gap_cycles);
        return 2 + 2 * half_cyc * (cmd_bits + data_bits) + gap_cycles;
    endfunction

    function automatic logic is_wr(input sfc_state_e s);
        return (s == StWrLo) || (s == StWrHi);
    endfunction

    function automatic logic is_rd(input sfc_state_e s);
        return (s == StRdLo) || (s == StRdHi);
    endfunction

endpackage

// File: rtl/sfc_phase_timer.sv
// Phase, bit and gap counters for the serial frame controller.
// Counters are driven by the current and next FSM state so that the top can
// register its strobes one cycle ahead and keep every output flop-driven.
module sfc_phase_timer
    import serial_frame_pkg::*;
#(
    parameter int unsigned CMD_BITS   = 7,
    parameter int unsigned DATA_BITS  = 10,
    parameter int unsigned HALF_CYC   = 1,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  sfc_state_e cur_state,
    input  sfc_state_e nxt_state,
    output logic       phase_last,
    output logic       bit_last,
    output logic       phase_last_nxt
);

    localparam int unsigned MaxBits = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
    localparam int unsigned BitW    = $clog2(MaxBits + 1);
    localparam int unsigned PhW     = ($clog2(HALF_CYC) > 1) ? $clog2(HALF_CYC) : 1;
    localparam int unsigned GapW    = $clog2(GAP_CYCLES + 1);

    localparam logic [PhW-1:0]  PhLast   = PhW'(HALF_CYC - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [BitW-1:0] CmdLast  = BitW'(CMD_BITS - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);

    logic [PhW-1:0]  ph_q, ph_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [BitW-1:0] bit_q, bit_d;

    // Next counter values: count while staying in a timed state, wrap to 0 on exit.
    always_comb begin
        ph_d  = '0;
        gap_d = '0;
        bit_d = '0;
        if ((is_wr(nxt_state) || is_rd(nxt_state)) && (nxt_state == cur_state)) begin
            ph_d = ph_q + 1'b1;
        end
        if ((nxt_state == StEnd) && (cur_state == StEnd)) begin
            gap_d = gap_q + 1'b1;
        end
        if (((cur_state == StWrHi) && (nxt_state == StWrLo)) ||
            ((cur_state == StRdHi) && (nxt_state == StRdLo))) begin
            bit_d = bit_q + 1'b1;
        end else if ((is_wr(cur_state) && is_wr(nxt_state)) ||
                     (is_rd(cur_state) && is_rd(nxt_state))) begin
            bit_d = bit_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            gap_q <= '0;
            bit_q <= '0;
        end else begin
            ph_q  <= ph_d;
            gap_q <= gap_d;
            bit_q <= bit_d;
        end
    end

    // Last-cycle flags for the current cycle and for the upcoming cycle.
    always_comb begin
        phase_last     = 1'b0;
        phase_last_nxt = 1'b0;
        bit_last       = 1'b0;
        if (is_wr(cur_state) || is_rd(cur_state)) begin
            phase_last = (ph_q == PhLast);
        end else if (cur_state == StEnd) begin
            phase_last = (gap_q == GapLast);
        end
        if (is_wr(nxt_state) || is_rd(nxt_state)) begin
            phase_last_nxt = (ph_d == PhLast);
        end else if (nxt_state == StEnd) begin
            phase_last_nxt = (gap_d == GapLast);
        end
        if (is_wr(cur_state)) begin
            bit_last = (bit_q == CmdLast);
        end else if (is_rd(cur_state)) begin
            bit_last = (bit_q == DataLast);
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Master-side tclk/trst/dq frame controller: command write then data read.
// All outputs are registered from the next state, so each output reflects the
// state it belongs to in the same cycle without any combinational decode.
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int unsigned CMD_BITS   = 7,
    parameter int unsigned DATA_BITS  = 10,
    parameter int unsigned HALF_CYC   = 1,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 auto,
    input  logic                 abort,
    input  logic [CMD_BITS-1:0]  cmd,
    output logic                 ready,
    output logic                 done,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 tclk,
    output logic                 trst,
    output logic                 dq_out,
    output logic                 dq_en,
    input  logic                 dq_in,
    output logic                 sr_en
);

    sfc_state_e state_q, state_d;

    logic [CMD_BITS-1:0]  wr_q, wr_d;
    logic [DATA_BITS-1:0] rd_q, rd_d;

    logic phase_last;
    logic bit_last;
    logic phase_last_nxt;

    logic done_nxt;
    logic sr_en_nxt;

    sfc_phase_timer #(
        .CMD_BITS   (CMD_BITS),
        .DATA_BITS  (DATA_BITS),
        .HALF_CYC   (HALF_CYC),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .cur_state      (state_q),
        .nxt_state      (state_d),
        .phase_last     (phase_last),
        .bit_last       (bit_last),
        .phase_last_nxt (phase_last_nxt)
    );

    // Next-state decode; abort overrides everything, start is only seen in
    // IDLE or the last END cycle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start || auto) state_d = StLoad;
                end
                StLoad:  state_d = StStart;
                StStart: state_d = StWrLo;
                StWrLo: begin
                    if (phase_last) state_d = StWrHi;
                end
                StWrHi: begin
                    if (phase_last) state_d = bit_last ? StRdLo : StWrLo;
                end
                StRdLo: begin
                    if (phase_last) state_d = StRdHi;
                end
                StRdHi: begin
                    if (phase_last) state_d = bit_last ? StEnd : StRdLo;
                end
                StEnd: begin
                    if (phase_last) state_d = (start || auto) ? StLoad : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Shift register next values: load in LOAD, shift on the strobe cycles.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (state_q == StLoad) begin
            wr_d = cmd;
        end else if ((state_q == StWrHi) && phase_last) begin
            wr_d = wr_q << 1;
        end
        if ((state_q == StRdLo) && phase_last) begin
            rd_d = (rd_q << 1) | DATA_BITS'(dq_in);
        end
    end

    // Strobes for the upcoming cycle; abort drives state_d to IDLE so it
    // suppresses done and rd_data capture automatically.
    always_comb begin
        done_nxt  = (state_d == StEnd) && phase_last_nxt;
        sr_en_nxt = ((state_d == StWrHi) || (state_d == StRdLo)) && phase_last_nxt;
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // FSM state and registered link/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ready   <= 1'b1;
            tclk    <= 1'b1;
            trst    <= 1'b0;
            dq_out  <= 1'b0;
            dq_en   <= 1'b0;
            sr_en   <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == StIdle);
            tclk    <= !((state_d == StWrLo) || (state_d == StRdLo));
            dq_en   <= is_wr(state_d);
            dq_out  <= is_wr(state_d) ? wr_d[CMD_BITS-1] : 1'b0;
            sr_en   <= sr_en_nxt;
            done    <= done_nxt;
            unique case (state_d)
                StIdle:  trst <= 1'b0;
                // LOAD keeps the previous level: low after IDLE, high when a
                // frame follows END back to back so the link is never reset.
                StLoad:  trst <= trst;
                default: trst <= 1'b1;
            endcase
            if (done_nxt) begin
                rd_data <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: default and non-default parameter sets.
module tb_serial_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic       a_start = 1'b0, a_auto = 1'b0, a_abort = 1'b0, a_dq_in = 1'b0;
    logic [6:0] a_cmd = '0;
    logic       a_ready, a_done, a_tclk, a_trst, a_dq_out, a_dq_en, a_sr_en;
    logic [9:0] a_rd_data;

    // Instance B: HALF_CYC=3, CMD_BITS=4, DATA_BITS=4, GAP_CYCLES=2.
    logic       b_start = 1'b0, b_auto = 1'b0, b_abort = 1'b0, b_dq_in = 1'b0;
    logic [3:0] b_cmd = '0;
    logic       b_ready, b_done, b_tclk, b_trst, b_dq_out, b_dq_en, b_sr_en;
    logic [3:0] b_rd_data;

    serial_frame_ctrl u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (a_start),
        .auto    (a_auto),
        .abort   (a_abort),
        .cmd     (a_cmd),
        .ready   (a_ready),
        .done    (a_done),
        .rd_data (a_rd_data),
        .tclk    (a_tclk),
        .trst    (a_trst),
        .dq_out  (a_dq_out),
        .dq_en   (a_dq_en),
        .dq_in   (a_dq_in),
        .sr_en   (a_sr_en)
    );

    serial_frame_ctrl #(
        .CMD_BITS   (4),
        .DATA_BITS  (4),
        .HALF_CYC   (3),
        .GAP_CYCLES (2)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (b_start),
        .auto    (b_auto),
        .abort   (b_abort),
        .cmd     (b_cmd),
        .ready   (b_ready),
        .done    (b_done),
        .rd_data (b_rd_data),
        .tclk    (b_tclk),
        .trst    (b_trst),
        .dq_out  (b_dq_out),
        .dq_en   (b_dq_en),
        .dq_in   (b_dq_in),
        .sr_en   (b_sr_en)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave models: present the next read bit on each read-phase tclk fall,
    // record written bits on each write strobe, count done pulses.
    logic [9:0] a_rd_word = '0;
    int         a_ridx = 0;
    logic       a_prev_tclk = 1'b1;
    logic [6:0] a_wr_seen = '0;
    int         a_wr_cnt = 0;
    int         a_done_cnt = 0;

    initial begin : a_model
        forever begin
            @(posedge clk);
            #1;
            if (a_dq_en) a_ridx = 0;
            else if (a_trst && a_prev_tclk && !a_tclk && a_ridx < 10) begin
                a_dq_in = a_rd_word[9-a_ridx];
                a_ridx++;
            end
            if (a_sr_en && a_dq_en) begin
                a_wr_seen = {a_wr_seen[5:0], a_dq_out};
                a_wr_cnt++;
            end
            if (a_done) a_done_cnt++;
            a_prev_tclk = a_tclk;
        end
    end

    logic [3:0] b_rd_word = '0;
    int         b_ridx = 0;
    logic       b_prev_tclk = 1'b1;
    logic [3:0] b_wr_seen = '0;

    initial begin : b_model
        forever begin
            @(posedge clk);
            #1;
            if (b_dq_en) b_ridx = 0;
            else if (b_trst && b_prev_tclk && !b_tclk && b_ridx < 4) begin
                b_dq_in = b_rd_word[3-b_ridx];
                b_ridx++;
            end
            if (b_sr_en && b_dq_en) b_wr_seen = {b_wr_seen[2:0], b_dq_out};
            b_prev_tclk = b_tclk;
        end
    end

    // Main-thread sampling point sits after the models have updated.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_check_reset(input string tag);
        check_eq({tag, " ready"}, a_ready, 1);
        check_eq({tag, " tclk"}, a_tclk, 1);
        check_eq({tag, " trst"}, a_trst, 0);
        check_eq({tag, " dq_out"}, a_dq_out, 0);
        check_eq({tag, " dq_en"}, a_dq_en, 0);
        check_eq({tag, " sr_en"}, a_sr_en, 0);
        check_eq({tag, " done"}, a_done, 0);
        check_eq({tag, " rd_data"}, a_rd_data, 0);
    endtask

    // One start-pulsed frame on A; latency counts the sampling edge as 1.
    task automatic a_frame(input string tag, input logic [6:0] c, input logic [9:0] w,
                           input logic [6:0] exp_bits);
        int n;
        a_cmd = c;
        a_rd_word = w;
        a_wr_cnt = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_done && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, " latency"}, n, 40);
        check_eq({tag, " rd_data"}, a_rd_data, w);
        check_eq({tag, " dq_out bits"}, a_wr_seen, exp_bits);
        check_eq({tag, " write shifts"}, a_wr_cnt, 7);
        tick();
        check_eq({tag, " ready after"}, a_ready, 1);
    endtask

    initial begin : main
        int n, base, rises, k, trst_low, ready_hi, seen_hi, dn;
        int d_at[3];
        int run, lo_min, lo_max, lo_runs, last_fall, iv_min, iv_max, sr_cnt;
        logic pt;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        a_check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("idle ready", a_ready, 1);
        check_eq("idle trst", a_trst, 0);

        // Basic frame: 7'h5A shifts out as 1,0,1,1,0,1,0.
        a_frame("frame1", 7'h5A, 10'h2B3, 7'b1011010);

        // start held through most of the frame then dropped before END.
        a_cmd = 7'h33;
        a_rd_word = 10'h155;
        a_start = 1'b1;
        tick();
        n = 1;
        while (!a_done && n < 100) begin
            if (n == 20) a_start = 1'b0;
            tick();
            n++;
        end
        check_eq("held latency", n, 40);
        check_eq("held rd_data", a_rd_data, 10'h155);
        base = a_done_cnt;
        ready_hi = 0;
        repeat (45) begin
            tick();
            if (a_ready) ready_hi++;
        end
        check_eq("held no second done", a_done_cnt - base, 0);
        check_eq("held ready stays", ready_hi, 45);

        // start raised in the last END cycle launches the next frame at once.
        a_cmd = 7'h01;
        a_rd_word = 10'h201;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_done && n < 100) begin
            tick();
            n++;
        end
        check_eq("b2b first latency", n, 40);
        a_rd_word = 10'h0C3;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_eq("b2b no ready gap", a_ready, 0);
        check_eq("b2b trst held", a_trst, 1);
        n = 1;
        while (!a_done && n < 100) begin
            tick();
            n++;
        end
        check_eq("b2b second latency", n, 40);
        check_eq("b2b rd_data", a_rd_data, 10'h0C3);
        tick();

        // Free-running: three frames on auto.
        a_cmd = 7'h40;
        a_rd_word = 10'h0F0;
        a_auto = 1'b1;
        k = 0;
        dn = 0;
        trst_low = 0;
        ready_hi = 0;
        seen_hi = 0;
        d_at[0] = 0;
        d_at[1] = 0;
        d_at[2] = 0;
        while (dn < 3 && k < 200) begin
            tick();
            k++;
            if (a_ready) ready_hi++;
            if (a_trst) seen_hi = 1;
            else if (seen_hi != 0) trst_low++;
            if (a_done) begin
                d_at[dn] = k;
                dn++;
                if (dn == 3) a_auto = 1'b0;
            end
        end
        a_auto = 1'b0;
        check_eq("auto done count", dn, 3);
        check_eq("auto first done", d_at[0], 40);
        check_eq("auto spacing 1", d_at[1] - d_at[0], 40);
        check_eq("auto spacing 2", d_at[2] - d_at[1], 40);
        check_eq("auto trst low", trst_low, 0);
        check_eq("auto ready high", ready_hi, 0);
        check_eq("auto rd_data", a_rd_data, 10'h0F0);
        tick();
        check_eq("auto stops", a_ready, 1);

        // Abort in RD_HI of read bit 5.
        a_cmd = 7'h7F;
        a_rd_word = 10'h3FF;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        pt = a_tclk;
        rises = 0;
        n = 1;
        while (rises < 6 && n < 100) begin
            tick();
            n++;
            if (!a_dq_en && a_trst && a_tclk && !pt) rises++;
            pt = a_tclk;
        end
        check_eq("abort reached rd bit5", rises, 6);
        base = a_done_cnt;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check_eq("abort trst", a_trst, 0);
        check_eq("abort tclk", a_tclk, 1);
        check_eq("abort ready", a_ready, 1);
        check_eq("abort done", a_done, 0);
        check_eq("abort rd_data held", a_rd_data, 10'h0F0);
        repeat (50) tick();
        check_eq("abort no done", a_done_cnt - base, 0);

        // Asynchronous reset during WR_LO, then a clean frame.
        a_cmd = 7'h5A;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (!(a_dq_en && !a_tclk) && n < 20) begin
            tick();
            n++;
        end
        check_eq("rst reached wr_lo", a_dq_en && !a_tclk, 1);
        #1;
        rst_n = 1'b0;
        #1;
        a_check_reset("midframe reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a_frame("after reset", 7'h5A, 10'h2B3, 7'b1011010);

        // Instance B: 3-cycle tclk phases, 4+4 bits, 2 gap cycles.
        b_cmd = 4'hC;
        b_rd_word = 4'h9;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 1;
        run = 0;
        lo_min = 1000;
        lo_max = 0;
        lo_runs = 0;
        last_fall = -1;
        iv_min = 1000;
        iv_max = 0;
        sr_cnt = 0;
        pt = b_tclk;
        while (n < 100) begin
            if (b_sr_en) sr_cnt++;
            if (!b_tclk) run++;
            else if (run > 0) begin
                if (run < lo_min) lo_min = run;
                if (run > lo_max) lo_max = run;
                lo_runs++;
                run = 0;
            end
            if (pt && !b_tclk) begin
                if (last_fall >= 0) begin
                    if (n - last_fall < iv_min) iv_min = n - last_fall;
                    if (n - last_fall > iv_max) iv_max = n - last_fall;
                end
                last_fall = n;
            end
            pt = b_tclk;
            if (b_done) break;
            tick();
            n++;
        end
        check_eq("B latency", n, 52);
        check_eq("B rd_data", b_rd_data, 4'h9);
        check_eq("B dq_out bits", b_wr_seen, 4'hC);
        check_eq("B sr_en pulses", sr_cnt, 8);
        check_eq("B low phases", lo_runs, 8);
        check_eq("B low min", lo_min, 3);
        check_eq("B low max", lo_max, 3);
        check_eq("B period min", iv_min, 6);
        check_eq("B period max", iv_max, 6);
        tick();
        check_eq("B ready after", b_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Parametrised master-side controller for the tclk/trst/dq serial link: frames a command write followed by a data read, with an internal cycle timer, programmable bit counts and clock half-period, and a start/ready/done handshake. It sits between the host-side command logic and the pad-level tristate buffer. It replaces externally counted fixed 40-cycle framing. All link outputs are flop-driven, so they are glitch-free.

## Interface
- CMD_BITS, 7: command bits shifted out per frame, MSB first; ≥1
- DATA_BITS, 10: data bits captured per frame, MSB first; ≥1
- HALF_CYC, 1: clk cycles per tclk low phase and per tclk high phase; ≥1
- GAP_CYCLES, 4: END cycles (tclk=1, trst=1) closing each frame; ≥1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a frame; sampled only when ready=1 or in the last END cycle
- auto  in  1  free-run: when 1, a new frame follows END without start
- abort  in  1  synchronous abort; forces IDLE on the next edge
- cmd  in  CMD_BITS  command word, latched in LOAD
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse in the final END cycle
- rd_data  out  DATA_BITS  captured data; updated in the final END cycle, otherwise held
- tclk  out  1  serial clock
- trst  out  1  link reset, active low
- dq_out  out  1  serial write data
- dq_en  out  1  tristate enable for dq_out
- dq_in  in  1  serial read data
- sr_en  out  1  shift strobe, high in every cycle a shift register moves

## Operation
- States: IDLE, LOAD, START, WR_LO, WR_HI, RD_LO, RD_HI, END. The state enum lives in the package.
- IDLE: tclk=1, trst=0, dq_en=0. Goes to LOAD when start=1 or auto=1.
- LOAD: 1 cycle; latches cmd into the write shift register; trst=0, tclk=1. Goes to START.
- START: 1 cycle; trst=1, tclk=1. Goes to WR_LO.
- WR_LO/WR_HI: each lasts HALF_CYC cycles; tclk=0/1; dq_en=1; dq_out = write-register MSB.
  - In the last WR_HI cycle: sr_en=1, the register shifts left, and the bit counter increments.
  - After bit CMD_BITS-1, go to RD_LO; otherwise go to WR_LO.
- RD_LO/RD_HI: each lasts HALF_CYC cycles; tclk=0/1; dq_en=0.
  - In the last RD_LO cycle: sr_en=1, and dq_in shifts into the read register LSB.
  - After bit DATA_BITS-1, go to END.
- END: GAP_CYCLES cycles; tclk=1, trst=1, dq_en=0.
  - In the last cycle: done=1 and rd_data ← read register.
  - Then go to LOAD if start or auto is high; otherwise go to IDLE.
- Outside WR states: dq_out=0. Outside the named strobe cycles: sr_en=0.
- abort (any state other than IDLE): next state IDLE, counters cleared, no done, rd_data unchanged. abort has priority over start and auto.
- start during a frame is ignored, except in the last END cycle.

## Timing
- Reset values: tclk=1, trst=0, dq_out=0, dq_en=0, sr_en=0, done=0, rd_data=0, ready=1; state IDLE.
- Reset mid-frame returns all outputs to these values immediately.
- Frame length from the start-sampling edge to the done cycle: 2 + 2·HALF_CYC·(CMD_BITS+DATA_BITS) + GAP_CYCLES cycles. With defaults this is 40.
- Back-to-back frames (start or auto high in the last END cycle): LOAD follows directly; no IDLE cycle, no ready pulse.
- tclk duty cycle is exactly 50% inside WR/RD; there is no tclk edge between LOAD, START and END.
- Counter widths: bit counter $clog2(max(CMD_BITS,DATA_BITS)+1); phase counter max(1,$clog2(HALF_CYC)); gap counter $clog2(GAP_CYCLES+1). Counters saturate-free and wrap to 0 on phase exit.

## Structure
- Package serial_frame_pkg: state enum and the frame-length localparam function.
- Sub-module sfc_phase_timer: phase, bit and gap counters. It outputs phase_last and bit_last to the FSM.
- Shift registers and output flops live in the top module.

## Test plan
- Defaults, cmd=7'h5A, dq_in driven by a model returning 10'h2B3 → done exactly 40 cycles after start; rd_data=10'h2B3; dq_out sequence 1,0,1,1,0,1,0.
- HALF_CYC=3, CMD_BITS=4, DATA_BITS=4, GAP_CYCLES=2 → each tclk phase lasts 3 cycles; done 2+48+2=52 cycles after start; 8 sr_en pulses.
- auto=1 for 3 frames → 3 done pulses spaced 40 cycles apart; trst never low between frames; ready stays 0.
- abort asserted in RD_HI of bit 5 → next cycle IDLE with trst=0, tclk=1; no done; rd_data holds its previous value.
- rst_n dropped during WR_LO → outputs at reset values with no clock edge; a frame after release behaves as in scenario 1.
- start held high during the frame and released before END → no second frame; start high in the last END cycle → LOAD the next cycle.
